// File: rtl/uart_io_sched.sv
// uart_io_sched: owns the shared UART unit; buffers core output bytes in a TX
// FIFO and received bytes in an RX FIFO, issuing one go/rors/done operation
// at a time with transmit taking priority over receive.
module uart_io_sched #(
    parameter int unsigned TXDEPTH_LOG = 4,
    parameter int unsigned RXDEPTH_LOG = 2,
    parameter bit          PREFETCH    = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       rx_req,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ack,
    output logic       uart_go,
    output logic       uart_rors,
    output logic [7:0] uart_txdata,
    input  logic       uart_done,
    input  logic [7:0] uart_rxdata,
    output logic       tx_empty,
    output logic       busy
);

    localparam int unsigned TXDEPTH = 1 << TXDEPTH_LOG;
    localparam int unsigned RXDEPTH = 1 << RXDEPTH_LOG;
    localparam int unsigned TXPW    = TXDEPTH_LOG;
    localparam int unsigned RXPW    = RXDEPTH_LOG;
    localparam int unsigned TXCW    = TXDEPTH_LOG + 1;
    localparam int unsigned RXCW    = RXDEPTH_LOG + 1;

    typedef enum logic [1:0] {IDLE, TX_WAIT, RX_WAIT} state_e;

    state_e            state_q, state_d;
    logic [7:0]        tx_mem_q [TXDEPTH];
    logic [TXPW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TXCW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]        rx_mem_q [RXDEPTH];
    logic [7:0]        rx_mem_d [RXDEPTH];
    logic [RXPW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RXCW-1:0]   rx_cnt_q, rx_cnt_d;
    logic              go_q, go_d, rors_q, rors_d;
    logic [7:0]        txdata_q, txdata_d;
    logic              tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              tx_empty_q, tx_empty_d, busy_q, busy_d;
    logic              tx_push, tx_pop, rx_push, rx_pop;

    assign tx_push = tx_valid && tx_ready_q;
    assign rx_pop  = rx_ack && rx_valid_q;

    // Next-state and handshake decode: TX first, then RX if room and wanted
    always_comb begin
        state_d  = state_q;
        go_d     = 1'b0;
        rors_d   = rors_q;
        txdata_d = txdata_q;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_cnt_q != '0) begin
                    state_d  = TX_WAIT;
                    go_d     = 1'b1;
                    rors_d   = 1'b1;
                    txdata_d = tx_mem_q[tx_rptr_q];
                end else if ((rx_cnt_q != RXCW'(RXDEPTH)) && (rx_req || PREFETCH)) begin
                    state_d = RX_WAIT;
                    go_d    = 1'b1;
                    rors_d  = 1'b0;
                end
            end
            TX_WAIT: begin
                if (uart_done) begin
                    tx_pop  = 1'b1;
                    state_d = IDLE;
                end
            end
            RX_WAIT: begin
                if (uart_done) begin
                    rx_push = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer/count update and registered status flags
    always_comb begin
        tx_wptr_d = tx_push ? tx_wptr_q + TXPW'(1) : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + TXPW'(1) : tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + TXCW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TXCW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        rx_mem_d  = rx_mem_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = uart_rxdata;
        end
        rx_wptr_d = rx_push ? rx_wptr_q + RXPW'(1) : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + RXPW'(1) : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + RXCW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RXCW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        tx_ready_d = (tx_cnt_d != TXCW'(TXDEPTH));
        rx_valid_d = (rx_cnt_d != '0);
        rx_data_d  = rx_mem_d[rx_rptr_d];
        tx_empty_d = (tx_cnt_d == '0) && (state_d != TX_WAIT);
        busy_d     = (state_d != IDLE);
    end

    // TX storage; contents only meaningful where count says so
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= tx_data;
        end
    end

    // Control, RX storage and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            for (int unsigned i = 0; i < RXDEPTH; i++) begin
                rx_mem_q[i] <= '0;
            end
            go_q       <= 1'b0;
            rors_q     <= 1'b0;
            txdata_q   <= '0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_empty_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_mem_q   <= rx_mem_d;
            go_q       <= go_d;
            rors_q     <= rors_d;
            txdata_q   <= txdata_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_empty_q <= tx_empty_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign uart_go     = go_q;
    assign uart_rors   = rors_q;
    assign uart_txdata = txdata_q;
    assign tx_empty    = tx_empty_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_io_sched.md
Name: uart_io_sched

Overview:
- Scheduler that owns the single shared UART unit and serves the core's byte output and byte input requests.
- Buffers outgoing bytes in a TX FIFO so stores to the output port do not stall the core.
- Buffers received bytes in an RX FIFO and sequences the unit's go/rors/done handshake, one operation at a time.
- Sits between the controller/datapath and uart_unit in the core top level.

Parameters:
TXDEPTH_LOG, 4, log2 of TX FIFO depth (16 entries)
RXDEPTH_LOG, 2, log2 of RX FIFO depth (4 entries)
PREFETCH, 0, 1 = issue reads whenever RX FIFO has room; 0 = only while rx_req is high

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
tx_valid  in  1  core offers byte tx_data
tx_data  in  8  byte to transmit
tx_ready  out  1  TX FIFO not full; byte accepted on edge where tx_valid&&tx_ready
rx_req  in  1  level: core wants an input byte
rx_valid  out  1  RX FIFO not empty
rx_data  out  8  RX FIFO head (show-ahead), valid when rx_valid
rx_ack  in  1  pop RX head on edge where rx_ack&&rx_valid
uart_go  out  1  one-cycle start pulse to uart_unit
uart_rors  out  1  operation select: 1 = send, 0 = read
uart_txdata  out  8  byte to send
uart_done  in  1  one-cycle completion pulse from uart_unit
uart_rxdata  in  8  received byte, valid in uart_done cycle of a read
tx_empty  out  1  TX FIFO empty and not in TX_WAIT (output fully drained)
busy  out  1  state != IDLE

Behaviour:
- Reset (rstn low, async): state IDLE; both FIFOs empty with pointers 0.
- Reset output values: uart_go=0, uart_rors=0, uart_txdata=0, tx_ready=1, rx_valid=0, rx_data=0, tx_empty=1, busy=0.
- FIFOs: circular, pointer width = DEPTH_LOG, count width = DEPTH_LOG+1; pointers wrap from depth-1 to 0.
- Simultaneous push and pop on the same FIFO in one cycle: both take effect, count unchanged. Allowed when full; TX push is blocked when full because tx_ready=0.
- Ignored requests: push when full (tx_valid with tx_ready=0) has no effect. rx_ack when empty has no effect.
- State machine: IDLE, TX_WAIT, RX_WAIT.
- IDLE, TX count>0: at the next edge go to TX_WAIT, uart_go=1, uart_rors=1, uart_txdata=TX head.
- IDLE, else RX count<depth and (rx_req or PREFETCH): at the next edge go to RX_WAIT, uart_go=1, uart_rors=0.
- IDLE, else: stay in IDLE.
- TX always has priority over RX when both are eligible.
- uart_go is registered and high for exactly one cycle (the first cycle of TX_WAIT/RX_WAIT).
- uart_rors and uart_txdata are held stable from go until the state leaves WAIT.
- TX_WAIT: on uart_done pop TX head, go to IDLE.
- RX_WAIT: on uart_done push uart_rxdata into RX FIFO, go to IDLE. Room was guaranteed at issue, since the core cannot push RX.
- A read in flight blocks transmission until a byte arrives. TX pushes during RX_WAIT are buffered normally.
- Latency: byte accepted at edge E0 → uart_go high in cycle after E1. done at edge Ed → IDLE; next go earliest in cycle after Ed+1.
- uart_done in IDLE: ignored.
- uart_done coinciding with go: not possible from the unit; no requirement.
- rx_req deasserted while in RX_WAIT: read still completes and the byte is buffered.
- Reset mid-operation: the FSM aborts and all FIFO contents are lost. uart_unit shares rstn.

Test Plan:
1. Single output: tx_valid=1, tx_data=8'h41 for 1 cycle → exactly one uart_go with rors=1, uart_txdata=8'h41. Drive done 100 cycles later → tx_empty=1, busy=0.
2. Burst and backpressure: push 20 bytes 8'h00..8'h13 back-to-back with done withheld → tx_ready drops after the 16th accepted (first sent byte in flight, pops on done). Releasing dones sends bytes in order 00..13 exactly once each.
3. Input (PREFETCH=0): rx_req=1, TX empty → uart_go with rors=0. done with uart_rxdata=8'h5A → rx_valid=1, rx_data=8'h5A. rx_ack → rx_valid=0. No further go once rx_req=0.
4. Priority: while in RX_WAIT push 8'h33 → no go until done. After done, next go has rors=1, txdata=8'h33, even though rx_req=1.
5. Prefetch (PREFETCH=1): rx_req=0, supply 5 reads with data 1..5 → only 4 reads issued; rx_data sequence 1,2,3,4. One rx_ack → a fifth read is issued.
6. Reset mid TX_WAIT with 3 bytes queued: rstn low 1 cycle → uart_go=0, tx_empty=1, tx_ready=1, rx_valid=0 immediately. No go after release until new push.
